// File: rtl/sobel_radicand_gen.sv
// Streaming 3x3 Sobel front end: two line buffers plus a sliding window feed a
// 3-stage pipeline that emits the saturated radicand Gx^2 + Gy^2 per interior pixel.
module sobel_radicand_gen #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    input  logic        sof,
    output logic [15:0] rad_out,
    output logic        rad_valid,
    output logic        rad_last
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;

    logic [7:0] lb1_q [IMG_W];
    logic [7:0] lb2_q [IMG_W];
    logic [7:0] w_q [3][3];

    logic               trig_q, last1_q;
    logic               v2_q, last2_q;
    logic signed [10:0] gx_q, gy_q, gx_d, gy_d;
    logic [15:0]        rad_out_q, rad_out_d;
    logic               rad_valid_q, rad_last_q;

    // sof overrides the counters so a partial frame is abandoned on the spot
    always_comb begin
        cur_col = sof ? '0 : col_q;
        cur_row = sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (pix_valid) begin
            if (cur_col == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1_q[cur_col] <= pix_in;
            lb2_q[cur_col] <= lb1_q[cur_col];
            for (int r = 0; r < 3; r++) begin
                w_q[r][0] <= w_q[r][1];
                w_q[r][1] <= w_q[r][2];
            end
            w_q[0][2] <= lb2_q[cur_col];
            w_q[1][2] <= lb1_q[cur_col];
            w_q[2][2] <= pix_in;
        end
    end

    function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return 10'(a) + (10'(b) << 1) + 10'(c);
    endfunction

    always_comb begin
        gx_d = $signed({1'b0, wsum(w_q[0][2], w_q[1][2], w_q[2][2])})
             - $signed({1'b0, wsum(w_q[0][0], w_q[1][0], w_q[2][0])});
        gy_d = $signed({1'b0, wsum(w_q[2][0], w_q[2][1], w_q[2][2])})
             - $signed({1'b0, wsum(w_q[0][0], w_q[0][1], w_q[0][2])});
    end

    always_ff @(posedge clk) begin
        gx_q <= gx_d;
        gy_q <= gy_d;
    end

    // Squaring magnitudes keeps the multipliers unsigned; 1020^2 * 2 fits in 21 bits
    logic [9:0]  gx_abs, gy_abs;
    logic [19:0] gx_sq, gy_sq;
    logic [20:0] sum_sq;

    always_comb begin
        gx_abs    = gx_q[10] ? 10'(-gx_q) : gx_q[9:0];
        gy_abs    = gy_q[10] ? 10'(-gy_q) : gy_q[9:0];
        gx_sq     = 20'(gx_abs) * 20'(gx_abs);
        gy_sq     = 20'(gy_abs) * 20'(gy_abs);
        sum_sq    = 21'(gx_sq) + 21'(gy_sq);
        rad_out_d = rad_out_q;
        if (v2_q) begin
            rad_out_d = (sum_sq > 21'd65535) ? 16'hFFFF : sum_sq[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            trig_q      <= 1'b0;
            last1_q     <= 1'b0;
            v2_q        <= 1'b0;
            last2_q     <= 1'b0;
            rad_out_q   <= '0;
            rad_valid_q <= 1'b0;
            rad_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            trig_q      <= pix_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
            last1_q     <= pix_valid && (cur_row == RW'(IMG_H - 1))
                                     && (cur_col == CW'(IMG_W - 1));
            v2_q        <= trig_q;
            last2_q     <= last1_q;
            rad_out_q   <= rad_out_d;
            rad_valid_q <= v2_q;
            rad_last_q  <= last2_q;
        end
    end

    assign rad_out   = rad_out_q;
    assign rad_valid = rad_valid_q;
    assign rad_last  = rad_last_q;

endmodule

// File: tb/tb_sobel_radicand_gen.sv
// Scoreboard bench for sobel_radicand_gen: the driver pushes expected radicands computed
// from a whole-image Sobel model; a negedge monitor pops them whenever rad_valid is seen.
module tb_sobel_radicand_gen;

    localparam int W = 8;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        sof;
    logic [15:0] rad_out;
    logic        rad_valid;
    logic        rad_last;

    sobel_radicand_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_in   (pix_in),
        .pix_valid(pix_valid),
        .sof      (sof),
        .rad_out  (rad_out),
        .rad_valid(rad_valid),
        .rad_last (rad_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int last;
    } exp_t;

    exp_t q[$];
    int   img[H][W];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_strobes = 0;
    int   n_pushed = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain Sobel on the stored image, center (r,c), saturated to 16 bits
    function automatic int ref_rad(input int r, input int c);
        int gx, gy, s;
        gx = (img[r-1][c+1] + 2 * img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2 * img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2 * img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2 * img[r-1][c] + img[r-1][c+1]);
        s = gx * gx + gy * gy;
        return (s > 65535) ? 65535 : s;
    endfunction

    function automatic int pattern_px(input int pat, input int r, input int c);
        case (pat)
            0:       return 100;
            1:       return (c < 2) ? 0 : 10;
            2:       return (r < 2) ? 0 : 10;
            3:       return (r == 3 && c == 3) ? 1 : 0;
            4:       return (c < 4) ? 0 : 255;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // Entered and left at posedge+1 with pix_valid low
    task automatic drive(input int v, input bit s);
        pix_in    = 8'(v);
        sof       = s;
        pix_valid = 1'b1;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    // Sends the first npix pixels of a frame; the last 'drop' outputs are not expected
    task automatic send_frame(input int pat, input int npix, input bit gaps, input int drop);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = pattern_px(pat, r, c);
        for (int p = 0; p < npix; p++) begin
            int r, c;
            r = p / W;
            c = p % W;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (r >= 2 && c >= 2 && p < npix - drop) begin
                q.push_back('{val: ref_rad(r - 1, c - 1),
                              last: (r == H - 1 && c == W - 1) ? 1 : 0});
                n_pushed++;
            end
            drive(img[r][c], p == 0);
        end
    endtask

    task automatic drain();
        repeat (6) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_frame(input string name, input int pat, input bit gaps);
        int s0;
        s0 = n_strobes;
        send_frame(pat, W * H, gaps, 0);
        drain();
        check({name, "_strobe_count"}, n_strobes - s0, (W - 2) * (H - 2));
        check({name, "_queue_empty"}, q.size(), 0);
    endtask

    int last_val = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_val = 0;
        end else if (rad_valid) begin
            n_strobes++;
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: got rad_out=%0d, expected no strobe (t=%0t)",
                         rad_out, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rad_out", int'(rad_out), e.val);
                check("rad_last", int'(rad_last), e.last);
            end
            last_val = int'(rad_out);
        end else begin
            check("rad_out_hold", int'(rad_out), last_val);
            check("rad_last_idle", int'(rad_last), 0);
        end
    end

    initial begin
        int s0, p0;
        rst_n     = 1'b0;
        pix_in    = '0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        #12;
        check("reset_rad_out", int'(rad_out), 0);
        check("reset_rad_valid", int'(rad_valid), 0);
        check("reset_rad_last", int'(rad_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_frame("const100", 0, 1'b0);
        run_frame("vedge", 1, 1'b0);
        run_frame("hedge", 2, 1'b0);
        run_frame("impulse", 3, 1'b0);
        run_frame("saturate", 4, 1'b0);
        run_frame("vedge_gaps", 1, 1'b1);
        run_frame("random", 5, 1'b0);
        run_frame("random_gaps", 5, 1'b1);

        // Back-to-back frames with no idle cycle between them
        s0 = n_strobes;
        send_frame(5, W * H, 1'b0, 0);
        send_frame(2, W * H, 1'b0, 0);
        drain();
        check("b2b_strobe_count", n_strobes - s0, 2 * (W - 2) * (H - 2));
        check("b2b_queue_empty", q.size(), 0);

        // sof mid-frame: in-flight strobes of the old frame still emerge
        s0 = n_strobes;
        p0 = n_pushed;
        send_frame(5, 30, 1'b0, 0);
        send_frame(0, W * H, 1'b0, 0);
        drain();
        check("sof_mid_strobe_count", n_strobes - s0, n_pushed - p0);
        check("sof_mid_new_frame", n_pushed - p0, 10 + (W - 2) * (H - 2));
        check("sof_mid_queue_empty", q.size(), 0);

        // Reset mid-frame right after a trigger strobe reaches the output
        send_frame(5, 4 * W + 5, 1'b0, 3);
        rst_n = 1'b0;
        #1;
        check("async_reset_rad_valid", int'(rad_valid), 0);
        check("async_reset_rad_last", int'(rad_last), 0);
        check("async_reset_queue", q.size(), 0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame("after_reset", 5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
